// File: rtl/game_period_seq_pkg.sv
// Shared types and constants for the game-phase sequencer (package game_pkg).
// Optional build macro: GAME_PAUSE_EN (adds a Pause input that masks Tick1Hz).
package game_pkg;

  localparam int SECS_W  = 7;
  localparam int LEVEL_W = 4;

  localparam int PRELIM_SECS_DEF = 5;
  localparam int ANSWER_SECS_DEF = 30;
  localparam int POST_SECS_DEF   = 3;
  localparam int MAX_LEVEL_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    ANSWER = 3'd2,
    POST   = 3'd3,
    DONE   = 3'd4
  } game_state_t;

  // True for the three periods that consume seconds ticks.
  function automatic logic is_timed(input game_state_t st);
    return (st == PRELIM) || (st == ANSWER) || (st == POST);
  endfunction

endpackage

// File: rtl/game_period_seq_if.sv
// Bus between the tick/start source and the game-phase sequencer.
// Optional build macro: GAME_PAUSE_EN (adds Pause, driven by the master).
interface game_period_seq_if;
  import game_pkg::*;

  logic               Tick1Hz;
  logic               Start;
`ifdef GAME_PAUSE_EN
  logic               Pause;
`endif
  logic               PrelimPeriod;
  logic               AnswerPeriod;
  logic               PostPeriod;
  logic [LEVEL_W-1:0] Level;
  logic [SECS_W-1:0]  SecsLeft;
  logic               LevelChng;
  logic               GameOver;

`ifdef GAME_PAUSE_EN
  modport master (
    output Tick1Hz, Start, Pause,
    input  PrelimPeriod, AnswerPeriod, PostPeriod, Level, SecsLeft, LevelChng, GameOver
  );
  modport slave (
    input  Tick1Hz, Start, Pause,
    output PrelimPeriod, AnswerPeriod, PostPeriod, Level, SecsLeft, LevelChng, GameOver
  );
`else
  modport master (
    output Tick1Hz, Start,
    input  PrelimPeriod, AnswerPeriod, PostPeriod, Level, SecsLeft, LevelChng, GameOver
  );
  modport slave (
    input  Tick1Hz, Start,
    output PrelimPeriod, AnswerPeriod, PostPeriod, Level, SecsLeft, LevelChng, GameOver
  );
`endif

endinterface

// File: rtl/game_period_seq_sec_countdown.sv
// Loadable seconds down-counter. Load wins over tick; the count never
// decrements below 1 so a timed period never shows zero seconds.
module sec_countdown
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SECS_W-1:0] load_val,
  input  logic              tick,
  output logic [SECS_W-1:0] count,
  output logic              last_sec
);

  localparam logic [SECS_W-1:0] SECS_ONE = SECS_W'(32'd1);

  logic [SECS_W-1:0] count_r;

  // Seconds register: load a new period length or count one tick down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {SECS_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (tick && (count_r > SECS_ONE)) begin
      count_r <= count_r - SECS_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign last_sec = (count_r == SECS_ONE) && tick;

endmodule

// File: rtl/game_period_seq.sv
// Game-phase sequencer: walks each level through PRELIM, ANSWER and POST,
// counting 1 Hz ticks, and ends in DONE after MAX_LEVEL levels.
// Optional build macro: GAME_PAUSE_EN (Pause masks Tick1Hz; Start still honoured).
module game_period_seq
  import game_pkg::*;
#(
  parameter int PRELIM_SECS = PRELIM_SECS_DEF,
  parameter int ANSWER_SECS = ANSWER_SECS_DEF,
  parameter int POST_SECS   = POST_SECS_DEF,
  parameter int MAX_LEVEL   = MAX_LEVEL_DEF
)
(
  input  logic             Clk100M,
  input  logic             ResetN,
  game_period_seq_if.slave bus
);

  localparam logic [SECS_W-1:0]  PRELIM_LD = SECS_W'(PRELIM_SECS);
  localparam logic [SECS_W-1:0]  ANSWER_LD = SECS_W'(ANSWER_SECS);
  localparam logic [SECS_W-1:0]  POST_LD   = SECS_W'(POST_SECS);
  localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(32'd1);

  game_state_t        state_r;
  game_state_t        state_nxt_s;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] level_nxt_s;
  logic               lvl_chng_r;
  logic               lvl_chng_nxt_s;
  logic               prelim_r;
  logic               answer_r;
  logic               post_r;
  logic               over_r;

  logic               tick_eff_s;
  logic               cnt_tick_s;
  logic               cnt_load_s;
  logic [SECS_W-1:0]  cnt_val_s;
  logic [SECS_W-1:0]  secs_s;
  logic               last_sec_s;

`ifdef GAME_PAUSE_EN
  assign tick_eff_s = bus.Tick1Hz & ~bus.Pause;
`else
  assign tick_eff_s = bus.Tick1Hz;
`endif

  // Ticks only count down inside a timed period; IDLE/DONE ignore them.
  assign cnt_tick_s = tick_eff_s & is_timed(state_r);

  sec_countdown u_sec_countdown (
    .clk      (Clk100M),
    .rst_n    (ResetN),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .tick     (cnt_tick_s),
    .count    (secs_s),
    .last_sec (last_sec_s)
  );

  // Next-state, next-level and counter-load decode.
  always_comb begin
    state_nxt_s    = state_r;
    level_nxt_s    = level_r;
    lvl_chng_nxt_s = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_val_s      = {SECS_W{1'b0}};
    case (state_r)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_nxt_s = PRELIM;
          level_nxt_s = LEVEL_ONE;
          cnt_load_s  = 1'b1;
          cnt_val_s   = PRELIM_LD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      PRELIM: begin
        if (last_sec_s) begin
          state_nxt_s = ANSWER;
          cnt_load_s  = 1'b1;
          cnt_val_s   = ANSWER_LD;
        end else begin
          state_nxt_s = PRELIM;
        end
      end
      ANSWER: begin
        if (last_sec_s) begin
          state_nxt_s = POST;
          cnt_load_s  = 1'b1;
          cnt_val_s   = POST_LD;
        end else begin
          state_nxt_s = ANSWER;
        end
      end
      POST: begin
        if (last_sec_s) begin
          if (level_r < MAX_LVL) begin
            state_nxt_s    = PRELIM;
            level_nxt_s    = level_r + LEVEL_ONE;
            lvl_chng_nxt_s = 1'b1;
            cnt_load_s     = 1'b1;
            cnt_val_s      = PRELIM_LD;
          end else begin
            // Final level finished: clear seconds, keep the level on show.
            state_nxt_s = DONE;
            cnt_load_s  = 1'b1;
            cnt_val_s   = {SECS_W{1'b0}};
          end
        end else begin
          state_nxt_s = POST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        level_nxt_s = {LEVEL_W{1'b0}};
        cnt_load_s  = 1'b1;
        cnt_val_s   = {SECS_W{1'b0}};
      end
    endcase
  end

  // State, level and output flag registers; flags follow the registered state.
  always_ff @(posedge Clk100M or negedge ResetN) begin
    if (!ResetN) begin
      state_r    <= IDLE;
      level_r    <= {LEVEL_W{1'b0}};
      lvl_chng_r <= 1'b0;
      prelim_r   <= 1'b0;
      answer_r   <= 1'b0;
      post_r     <= 1'b0;
      over_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      level_r    <= level_nxt_s;
      lvl_chng_r <= lvl_chng_nxt_s;
      prelim_r   <= (state_nxt_s == PRELIM);
      answer_r   <= (state_nxt_s == ANSWER);
      post_r     <= (state_nxt_s == POST);
      over_r     <= (state_nxt_s == DONE);
    end
  end

  assign bus.PrelimPeriod = prelim_r;
  assign bus.AnswerPeriod = answer_r;
  assign bus.PostPeriod   = post_r;
  assign bus.Level        = level_r;
  assign bus.SecsLeft     = secs_s;
  assign bus.LevelChng    = lvl_chng_r;
  assign bus.GameOver     = over_r;

endmodule

// File: doc/game_period_seq.md
Name: game_period_seq

Overview:
- Game-phase sequencer directly downstream of the clock divider; consumes its one-cycle-wide 1 Hz tick pulse.
- Steps each level through PRELIM (symbol preview), ANSWER (player input window) and POST (score/result) periods, counting seconds.
- Drives period flags, level number, seconds-remaining and a level-change pulse to the symbol generator and display stages.

Parameters:
- PRELIM_SECS, 5, seconds in PRELIM period (1..127)
- ANSWER_SECS, 30, seconds in ANSWER period (1..127)
- POST_SECS, 3, seconds in POST period (1..127)
- MAX_LEVEL, 9, last level before DONE (1..15)

Ports:
- Clk100M  in  1  system clock, 100 MHz
- ResetN  in  1  asynchronous active-low reset
- Tick1Hz  in  1  one-cycle pulse once per second from clock divider
- Start  in  1  one-cycle pulse; starts a game from IDLE or DONE
- PrelimPeriod  out  1  high while in PRELIM
- AnswerPeriod  out  1  high while in ANSWER
- PostPeriod  out  1  high while in POST
- Level  out  4  current level, 0 in IDLE
- SecsLeft  out  7  seconds remaining in current period
- LevelChng  out  1  one-cycle pulse on entry to PRELIM of levels 2..MAX_LEVEL
- GameOver  out  1  high while in DONE

Behaviour:
- Reset (async assert, sync release to Clk100M): state=IDLE; all flags 0; Level=0; SecsLeft=0; LevelChng=0; GameOver=0.
- All outputs are registered. Flags are decoded from the state register, with no combinational path from inputs.
- States: IDLE, PRELIM, ANSWER, POST, DONE.
- IDLE or DONE with Start=1: next cycle state=PRELIM, Level=1, SecsLeft=PRELIM_SECS, GameOver=0. Tick1Hz is ignored in that cycle.
- Timed state (PRELIM/ANSWER/POST) with Tick1Hz=1:
  - SecsLeft>1: SecsLeft decrements by 1 the next cycle.
  - SecsLeft==1: transition the next cycle and load the new period's seconds:
    - PRELIM->ANSWER loads ANSWER_SECS.
    - ANSWER->POST loads POST_SECS.
    - POST with Level<MAX_LEVEL goes to PRELIM: Level+1, SecsLeft=PRELIM_SECS, LevelChng=1 for exactly that one cycle.
    - POST with Level==MAX_LEVEL goes to DONE: SecsLeft=0, GameOver=1, Level held.
- Tick1Hz=0 in a timed state: hold everything.
- Start while in PRELIM/ANSWER/POST: ignored.
- SecsLeft never reads 0 in a timed state. A period of N seconds lasts exactly N ticks.
- Tick1Hz in IDLE or DONE: ignored.
- Reset mid-game: immediately returns to IDLE values, regardless of state or pending tick.
- Level arithmetic is 4-bit and never exceeds MAX_LEVEL, so no wrap.
- LevelChng is never asserted for level 1 or on entry to DONE.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined: adds input port Pause (1 bit).
  - While Pause=1, Tick1Hz is masked: SecsLeft and state freeze, and Start is still honoured in IDLE/DONE.
  - A tick coincident with Pause=1 is lost, not deferred.
- Undefined: no Pause port; behaviour exactly as above.

Decomposition:
- Package game_pkg holds:
  - the state enum typedef (IDLE, PRELIM, ANSWER, POST, DONE);
  - width constants SECS_W=7 and LEVEL_W=4;
  - default period lengths.
- One natural sub-module: sec_countdown, a loadable SECS_W down-counter.
  - Inputs: load, load value, tick enable.
  - Outputs: count value, and last_sec flag (count==1 && tick), used for state transitions.

Test Plan (bench parameters PRELIM_SECS=2, ANSWER_SECS=3, POST_SECS=1, MAX_LEVEL=2; ticks spaced ≥4 cycles):
- Reset, then 5 ticks with no Start -> state IDLE, Level=0, SecsLeft=0, all flags 0.
- Start pulse -> next cycle PrelimPeriod=1, Level=1, SecsLeft=2. Tick -> SecsLeft=1. Tick -> AnswerPeriod=1, SecsLeft=3.
- Continue ticks to POST. At POST SecsLeft=1, tick -> PrelimPeriod=1, Level=2, SecsLeft=2, LevelChng high exactly one cycle.
- Run level 2 to completion (6 more ticks) -> GameOver=1, Level=2, SecsLeft=0, no LevelChng. Further ticks -> no change. Start -> PRELIM, Level=1.
- Start and Tick1Hz in the same cycle from IDLE -> SecsLeft=2, not 1. Start pulse during ANSWER -> ignored, SecsLeft unchanged.
- Assert ResetN=0 mid-ANSWER between clock edges -> outputs go to IDLE values immediately, without waiting for a clock edge. With GAME_PAUSE_EN: Pause=1 over 3 ticks -> SecsLeft frozen, no transition.
